// File: rtl/alu_op_sequencer_if.sv
// Handshake bundle between the datapath/ALU side and the ALU op sequencer.
// The sequencer connects through the slave modport; the datapath uses master.
interface alu_op_sequencer_if #(
    parameter int OP_W = 16
);
    logic            start;
    logic [OP_W-1:0] op_req;
    logic [OP_W-1:0] alu_op;
    logic [63:0]     z_in;
    logic [31:0]     z_hi;
    logic [31:0]     z_lo;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, op_req, z_in,
        input  alu_op, z_hi, z_lo, busy, done, err
    );

    modport slave (
        input  start, op_req, z_in,
        output alu_op, z_hi, z_lo, busy, done, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives the one-hot ALU op vector for one cycle (or DIV_CYCLES for DIV),
// captures the 64-bit Z result into HI/LO and pulses done.
module alu_op_sequencer #(
    parameter int OP_W       = 16,
    parameter int DIV_BIT    = 4,
    parameter int DIV_CYCLES = 34
) (
    input logic               clk,
    input logic               resetn,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DIV_WAIT, DONE} state_t;

    // A one-clock divide still needs a 1-bit counter to exist.
    localparam int                CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [OP_W-1:0]   DIV_OP   = OP_W'(1) << DIV_BIT;

    state_t          state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic [31:0]     z_hi_q, z_hi_d;
    logic [31:0]     z_lo_q, z_lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            req_onehot;

    assign req_onehot = (bus.op_req != '0) &&
                        ((bus.op_req & (bus.op_req - OP_W'(1))) == '0);

    // NOTE: every signal gets its hold/default value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        alu_op_d = alu_op_q;
        z_hi_d   = z_hi_q;
        z_lo_d   = z_lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!req_onehot) begin
                        err_d = 1'b1;
                    end else begin
                        alu_op_d = bus.op_req;
                        busy_d   = 1'b1;
                        if (bus.op_req == DIV_OP) begin
                            state_d = DIV_WAIT;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end
            end
            EXEC: begin
                z_hi_d   = bus.z_in[63:32];
                z_lo_d   = bus.z_in[31:0];
                alu_op_d = '0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DIV_WAIT: begin
                if (cnt == '0) begin
                    z_hi_d   = bus.z_in[63:32];
                    z_lo_d   = bus.z_in[31:0];
                    alu_op_d = '0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                alu_op_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // NOTE: the async reset clears alu_op immediately so the ALU (and the
    // divider) stop the moment resetn falls; sequential state uses <= only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            alu_op_q <= '0;
            z_hi_q   <= '0;
            z_lo_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            alu_op_q <= alu_op_d;
            z_hi_q   <= z_hi_d;
            z_lo_q   <= z_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.alu_op = alu_op_q;
    assign bus.z_hi   = z_hi_q;
    assign bus.z_lo   = z_lo_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a transaction-level model predicts
// alu_op, busy, done, err and the captured HI/LO for every cycle.
module tb_alu_op_sequencer;
    localparam int          OP_W       = 16;
    localparam int          DIV_BIT    = 4;
    localparam int          DIV_CYCLES = 34;
    localparam logic [15:0] ADD_OP     = 16'h0001;
    localparam logic [15:0] MUL_OP     = 16'h0008;
    localparam logic [15:0] DIV_OP     = 16'h0010;

    logic clk = 1'b0;
    logic resetn;

    alu_op_sequencer_if #(.OP_W(OP_W)) bus ();

    alu_op_sequencer #(
        .OP_W      (OP_W),
        .DIV_BIT   (DIV_BIT),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // What a well-behaved ALU would put on Z for a given op.
    function automatic logic [63:0] alu_model(input logic [15:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        case (op)
            16'h0001: return {32'h0, x + y};
            16'h0002: return {32'h0, x - y};
            16'h0008: return {32'h0, x} * {32'h0, y};
            16'h0010: return (y == 0) ? {x, 32'hffff_ffff} : {x % y, x / y};
            16'h1000: return {32'h0, x + 32'd1};
            default:  return {32'h0, x ^ y};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit stray);
        int          lat;
        logic [63:0] zr;
        check("idle_busy", bus.busy, 0);
        bus.start  = 1'b1;
        bus.op_req = op;
        bus.z_in   = {$urandom, $urandom};
        step();
        bus.start = 1'b0;

        if ($countones(op) != 1) begin
            check("err_pulse", bus.err, 1);
            check("err_busy", bus.busy, 0);
            check("err_done", bus.done, 0);
            check("err_alu_op", bus.alu_op, 0);
            step();
            check("err_clear", bus.err, 0);
            check("err_done2", bus.done, 0);
            check("err_z_hi", bus.z_hi, exp_hi);
            check("err_z_lo", bus.z_lo, exp_lo);
            return;
        end

        lat = (op == DIV_OP) ? DIV_CYCLES + 1 : 2;
        zr  = alu_model(op, x, y);
        for (int k = 1; k < lat; k++) begin
            check("alu_op", bus.alu_op, op);
            check("busy", bus.busy, 1);
            check("early_done", bus.done, 0);
            check("no_err", bus.err, 0);
            check("z_hold_hi", bus.z_hi, exp_hi);
            bus.start  = stray;
            bus.op_req = stray ? ((k % 2 == 1) ? ADD_OP : 16'($urandom)) : op;
            bus.z_in   = (k == lat - 1) ? zr : {$urandom, $urandom};
            step();
        end

        exp_hi = zr[63:32];
        exp_lo = zr[31:0];
        check("done", bus.done, 1);
        check("done_alu_op", bus.alu_op, 0);
        check("done_busy", bus.busy, 1);
        check("done_err", bus.err, 0);
        check("z_hi", bus.z_hi, exp_hi);
        check("z_lo", bus.z_lo, exp_lo);
        bus.start  = stray;
        bus.op_req = ADD_OP;
        bus.z_in   = {$urandom, $urandom};
        step();
        bus.start = 1'b0;
        check("post_done", bus.done, 0);
        check("post_busy", bus.busy, 0);
        check("post_alu_op", bus.alu_op, 0);
        check("post_z_lo", bus.z_lo, exp_lo);
    endtask

    initial begin
        logic [15:0] op;
        int          r;

        resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.op_req = '0;
        bus.z_in   = '0;
        repeat (2) @(negedge clk);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_z", {bus.z_hi, bus.z_lo}, 0);
        resetn = 1'b1;
        step();

        run_op(ADD_OP, 32'd10, 32'd5, 1'b0);
        check("add_result", bus.z_lo, 15);
        run_op(MUL_OP, 32'd4, 32'd3, 1'b0);
        check("mul_result", {bus.z_hi, bus.z_lo}, 12);
        run_op(DIV_OP, 32'd20, 32'd5, 1'b0);
        check("div_quot", bus.z_lo, 4);
        check("div_rem", bus.z_hi, 0);
        run_op(16'h0003, 32'd0, 32'd0, 1'b0);
        run_op(16'h0000, 32'd0, 32'd0, 1'b0);
        run_op(DIV_OP, 32'd1000, 32'd7, 1'b1);
        run_op(MUL_OP, 32'hffff_ffff, 32'hffff_ffff, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      op = 16'(1) << $urandom_range(0, 15);
            else if (r < 70) op = DIV_OP;
            else if (r < 80) op = '0;
            else             op = 16'($urandom) | (16'h0101 << $urandom_range(0, 7));
            run_op(op, $urandom, 32'($urandom_range(1, 1000)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a divide, with cnt at 20.
        bus.start  = 1'b1;
        bus.op_req = DIV_OP;
        step();
        bus.start = 1'b0;
        repeat (13) step();
        check("pre_rst_alu_op", bus.alu_op, DIV_OP);
        #2 resetn = 1'b0;
        #1;
        check("async_alu_op", bus.alu_op, 0);
        check("async_busy", bus.busy, 0);
        check("async_z_hi", bus.z_hi, 0);
        check("async_z_lo", bus.z_lo, 0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("rst_rel_busy", bus.busy, 0);
        run_op(ADD_OP, 32'd7, 32'd8, 1'b0);
        check("rst_add", bus.z_lo, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
